// File: rtl/bpsk_demod_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bpsk_demod_ctrl
// Sequencer for a BPSK demodulator. It lets the delay line fill after enable,
// then measures the spacing between edges of the recovered code. It collects
// a window of accepted intervals and classifies the shortest one into a code
// rate. On a valid rate it locks and switches the demodulator to decoded
// output. While locked it watches for short intervals and for silence, and
// drops back to acquisition when either shows the lock has gone.
//
// Ports
//   clk_32m    in   single clock, rising edge
//   rst        in   synchronous active-high reset (overrides en)
//   en         in   controller enable; 0 forces IDLE
//   code       in   recovered code level
//   demod_en   out  demodulator run enable
//   mode       out  1 = decoded code, 0 = raw passthrough
//   locked     out  rate lock indicator
//   rate       out  code rate in kbps (0, 6, 8, 10)
//   rate_valid out  one-cycle pulse when rate is newly set
//   state      out  IDLE=0, SETTLE=1, ACQ=2, LOCK=3
//
// Parameter ranges: SETTLE_CYC >= 1, MAX_INT <= 8191, TIMEOUT <= 65536.
// ---------------------------------------------------------------------------
module bpsk_demod_ctrl #(
  parameter int SETTLE_CYC = 64,
  parameter int WIN_EDGES  = 16,
  parameter int MAX_INT    = 5500,
  parameter int TIMEOUT    = 60000,
  parameter int ERR_MAX    = 4
) (
  input  logic       clk_32m,
  input  logic       rst,
  input  logic       en,
  input  logic       code,
  output logic       demod_en,
  output logic       mode,
  output logic       locked,
  output logic [7:0] rate,
  output logic       rate_valid,
  output logic [1:0] state
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int CW = $clog2(WIN_EDGES + 1);
  localparam int EW = $clog2(ERR_MAX + 1);

  localparam logic [12:0]   INT_SAT     = 13'h1FFF;
  localparam logic [12:0]   MAX_INT_V   = 13'(MAX_INT);
  localparam logic [15:0]   SIL_LAST    = 16'(TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] WIN_V       = CW'(WIN_EDGES);
  localparam logic [EW-1:0] ERR_V       = EW'(ERR_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACQ    = 2'd2,
    S_LOCK   = 2'd3
  } state_t;

  state_t        r_state,      w_state_next;
  logic          r_code_d;
  logic [12:0]   r_int_cnt,    w_int_cnt_next;
  logic [15:0]   r_sil_cnt,    w_sil_cnt_next;
  logic [SW-1:0] r_settle_cnt, w_settle_cnt_next;
  logic          r_armed,      w_armed_next;
  logic [12:0]   r_min,        w_min_next;
  logic [CW-1:0] r_acc_cnt,    w_acc_cnt_next;
  logic [EW-1:0] r_err_cnt,    w_err_cnt_next;
  logic [7:0]    r_rate,       w_rate_next;
  logic          r_rate_valid, w_rate_valid_next;
  logic          r_locked,     w_locked_next;
  logic          r_mode,       w_mode_next;
  logic          r_demod_en,   w_demod_en_next;

  // Rate bins, inclusive at both ends.
  function automatic logic [7:0] classify(input logic [12:0] v);
    if (v >= 13'd3100 && v <= 13'd3300)      classify = 8'd10;
    else if (v >= 13'd3900 && v <= 13'd4100) classify = 8'd8;
    else if (v >= 13'd5233 && v <= 13'd5433) classify = 8'd6;
    else                                     classify = 8'd0;
  endfunction

  // Lower edge of the bin that produced the locked rate.
  function automatic logic [12:0] bin_low(input logic [7:0] r);
    case (r)
      8'd10:   bin_low = 13'd3100;
      8'd8:    bin_low = 13'd3900;
      8'd6:    bin_low = 13'd5233;
      default: bin_low = 13'd0;
    endcase
  endfunction

  logic          w_edge;
  logic [12:0]   w_meas;
  logic          w_accept;
  logic          w_sil_hit;
  logic [CW-1:0] w_acc_inc;
  logic [12:0]   w_min_upd;
  logic [EW-1:0] w_err_inc;
  logic          w_short;

  assign w_edge    = code ^ r_code_d;
  // The counter holds spacing-1 at the edge; +1 gives the spacing itself.
  assign w_meas    = (r_int_cnt == INT_SAT) ? INT_SAT : r_int_cnt + 13'd1;
  assign w_accept  = w_edge && r_armed && (w_meas <= MAX_INT_V);
  // Silence would reach TIMEOUT this cycle; a coincident edge cancels it.
  assign w_sil_hit = (r_sil_cnt == SIL_LAST) && !w_edge;
  assign w_acc_inc = r_acc_cnt + 1'b1;
  assign w_min_upd = (w_meas < r_min) ? w_meas : r_min;
  assign w_err_inc = r_err_cnt + 1'b1;
  assign w_short   = w_meas < bin_low(r_rate);

  always_comb begin
    w_state_next      = r_state;
    w_settle_cnt_next = r_settle_cnt;
    w_armed_next      = r_armed;
    w_min_next        = r_min;
    w_acc_cnt_next    = r_acc_cnt;
    w_err_cnt_next    = r_err_cnt;
    w_rate_next       = r_rate;
    w_rate_valid_next = 1'b0;
    w_locked_next     = r_locked;
    w_mode_next       = r_mode;
    w_demod_en_next   = r_demod_en;
    w_sil_cnt_next    = w_edge ? 16'd0 : r_sil_cnt + 16'd1;
    if (w_edge)                  w_int_cnt_next = 13'd0;
    else if (r_int_cnt != INT_SAT) w_int_cnt_next = r_int_cnt + 13'd1;
    else                         w_int_cnt_next = r_int_cnt;

    case (r_state)
      S_IDLE: begin
        w_sil_cnt_next = 16'd0;
        if (en) begin
          w_state_next      = S_SETTLE;
          w_demod_en_next   = 1'b1;
          w_settle_cnt_next = '0;
        end
      end

      S_SETTLE: begin
        w_sil_cnt_next = 16'd0;
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state_next      = S_ACQ;
          w_settle_cnt_next = '0;
          w_armed_next      = 1'b0;
          w_min_next        = INT_SAT;
          w_acc_cnt_next    = '0;
        end else begin
          w_settle_cnt_next = r_settle_cnt + 1'b1;
        end
      end

      S_ACQ: begin
        if (w_sil_hit) begin
          // Dead air: start over and treat the next edge as a new arm.
          w_sil_cnt_next = 16'd0;
          w_armed_next   = 1'b0;
          w_min_next     = INT_SAT;
          w_acc_cnt_next = '0;
        end else if (w_edge && !r_armed) begin
          w_armed_next = 1'b1;
        end else if (w_accept) begin
          if (w_acc_inc == WIN_V) begin
            w_min_next     = INT_SAT;
            w_acc_cnt_next = '0;
            if (classify(w_min_upd) != 8'd0) begin
              w_state_next      = S_LOCK;
              w_rate_next       = classify(w_min_upd);
              w_rate_valid_next = 1'b1;
              w_locked_next     = 1'b1;
              w_mode_next       = 1'b1;
              w_err_cnt_next    = '0;
            end
          end else begin
            w_acc_cnt_next = w_acc_inc;
            w_min_next     = w_min_upd;
          end
        end
      end

      S_LOCK: begin
        if (w_sil_hit || (w_accept && w_short && w_err_inc == ERR_V)) begin
          w_state_next   = S_ACQ;
          w_locked_next  = 1'b0;
          w_mode_next    = 1'b0;
          w_rate_next    = 8'd0;
          w_armed_next   = 1'b0;
          w_min_next     = INT_SAT;
          w_acc_cnt_next = '0;
          w_err_cnt_next = '0;
          w_sil_cnt_next = 16'd0;
        end else if (w_accept && w_short) begin
          w_err_cnt_next = w_err_inc;
        end
      end

      default: w_state_next = S_IDLE;
    endcase

    // Disable beats every other transition.
    if (!en) begin
      w_state_next      = S_IDLE;
      w_settle_cnt_next = '0;
      w_int_cnt_next    = 13'd0;
      w_sil_cnt_next    = 16'd0;
      w_armed_next      = 1'b0;
      w_min_next        = INT_SAT;
      w_acc_cnt_next    = '0;
      w_err_cnt_next    = '0;
      w_rate_next       = 8'd0;
      w_rate_valid_next = 1'b0;
      w_locked_next     = 1'b0;
      w_mode_next       = 1'b0;
      w_demod_en_next   = 1'b0;
    end
  end

  always_ff @(posedge clk_32m) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_code_d     <= 1'b0;
      r_int_cnt    <= 13'd0;
      r_sil_cnt    <= 16'd0;
      r_settle_cnt <= '0;
      r_armed      <= 1'b0;
      r_min        <= INT_SAT;
      r_acc_cnt    <= '0;
      r_err_cnt    <= '0;
      r_rate       <= 8'd0;
      r_rate_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_mode       <= 1'b0;
      r_demod_en   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_code_d     <= code;
      r_int_cnt    <= w_int_cnt_next;
      r_sil_cnt    <= w_sil_cnt_next;
      r_settle_cnt <= w_settle_cnt_next;
      r_armed      <= w_armed_next;
      r_min        <= w_min_next;
      r_acc_cnt    <= w_acc_cnt_next;
      r_err_cnt    <= w_err_cnt_next;
      r_rate       <= w_rate_next;
      r_rate_valid <= w_rate_valid_next;
      r_locked     <= w_locked_next;
      r_mode       <= w_mode_next;
      r_demod_en   <= w_demod_en_next;
    end
  end

  assign state      = r_state;
  assign demod_en   = r_demod_en;
  assign mode       = r_mode;
  assign locked     = r_locked;
  assign rate       = r_rate;
  assign rate_valid = r_rate_valid;

endmodule

// File: tb/tb_bpsk_demod_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for bpsk_demod_ctrl. The stimulus process places code
// edges at chosen cycles and, from the interval list alone, predicts every
// state change (with its cycle and output values). The monitor compares
// each observed state change against that list in order.
module tb_bpsk_demod_ctrl;

  localparam int SETTLE_CYC = 64;
  localparam int WIN_EDGES  = 3;
  localparam int MAX_INT    = 5500;
  localparam int TIMEOUT    = 6000;
  localparam int ERR_MAX    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       code = 1'b0;
  logic       demod_en, mode, locked, rate_valid;
  logic [7:0] rate;
  logic [1:0] state;

  bpsk_demod_ctrl #(
    .SETTLE_CYC(SETTLE_CYC), .WIN_EDGES(WIN_EDGES), .MAX_INT(MAX_INT),
    .TIMEOUT(TIMEOUT), .ERR_MAX(ERR_MAX)
  ) u_dut (
    .clk_32m(clk), .rst(rst), .en(en), .code(code),
    .demod_en(demod_en), .mode(mode), .locked(locked),
    .rate(rate), .rate_valid(rate_valid), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [1:0] st;
    logic [7:0] rate;
    logic       lk, md, de, rv;
  } ev_t;

  ev_t exp_q[$];     // written only by stimulus
  int  req_cnt  = 0; // check requests from stimulus
  int  req_kind = 0; // 1 = all outputs idle, 2 = every expected event seen
  bit  mon_on   = 0;

  // ---------------- monitor / scoreboard ----------------
  int         n_vec = 0, n_err = 0, rd_idx = 0, ack_cnt = 0;
  bit         mon_started = 0;
  logic [1:0] prev_st;
  logic [7:0] prev_rate;
  ev_t        e;

  always @(negedge clk) begin
    if (mon_on) begin
      if (!mon_started) begin
        prev_st = state; prev_rate = rate; mon_started = 1;
      end
      if (state != prev_st) begin
        n_vec++;
        if (rd_idx >= exp_q.size()) begin
          n_err++;
          $display("FAIL unexpected_event t=%0d state=%0d rate=%0d", cyc, state, rate);
        end else begin
          e = exp_q[rd_idx];
          rd_idx++;
          if (e.t != cyc || e.st != state || e.rate != rate || e.lk != locked ||
              e.md != mode || e.de != demod_en || e.rv != rate_valid) begin
            n_err++;
            $display("FAIL event%0d got t=%0d st=%0d rate=%0d lk=%0b md=%0b de=%0b rv=%0b exp t=%0d st=%0d rate=%0d lk=%0b md=%0b de=%0b rv=%0b",
                     rd_idx, cyc, state, rate, locked, mode, demod_en, rate_valid,
                     e.t, e.st, e.rate, e.lk, e.md, e.de, e.rv);
          end else begin
            $display("ev%0d t=%0d state=%0d rate=%0d locked=%0b mode=%0b demod_en=%0b rate_valid=%0b",
                     rd_idx, cyc, state, rate, locked, mode, demod_en, rate_valid);
          end
        end
      end else if (rate_valid) begin
        n_err++;
        $display("FAIL stray_rate_valid t=%0d got 1 exp 0", cyc);
      end else if (state == 2'd3 && rate != prev_rate) begin
        n_err++;
        $display("FAIL rate_changed_in_lock t=%0d got %0d exp %0d", cyc, rate, prev_rate);
      end
      prev_st = state; prev_rate = rate;

      if (req_cnt != ack_cnt) begin
        ack_cnt = req_cnt;
        n_vec++;
        if (req_kind == 1) begin
          if (state != 2'd0 || demod_en || mode || locked || rate != 8'd0 || rate_valid) begin
            n_err++;
            $display("FAIL idle_outputs t=%0d got st=%0d de=%0b md=%0b lk=%0b rate=%0d rv=%0b exp all 0",
                     cyc, state, demod_en, mode, locked, rate, rate_valid);
          end else begin
            $display("chk t=%0d outputs idle", cyc);
          end
        end else begin
          if (rd_idx != exp_q.size()) begin
            n_err++;
            $display("FAIL events_seen t=%0d got %0d exp %0d", cyc, rd_idx, exp_q.size());
          end else begin
            $display("chk t=%0d all %0d expected events seen", cyc, rd_idx);
          end
        end
      end
    end
  end

  // ---------------- behavioural model (interval level) ----------------
  int m_prev, m_ref, m_last, m_cnt, m_min, m_err, m_rate;
  bit m_armed, m_locked;

  function automatic int cls(input int v);
    if (v >= 3100 && v <= 3300) return 10;
    if (v >= 3900 && v <= 4100) return 8;
    if (v >= 5233 && v <= 5433) return 6;
    return 0;
  endfunction

  function automatic int low_of(input int r);
    return (r == 10) ? 3100 : (r == 8) ? 3900 : 5233;
  endfunction

  task automatic push_ev(input int t, input int st, input int r,
                         input bit lk, input bit md, input bit de, input bit rv);
    ev_t x;
    x.t = t; x.st = 2'(st); x.rate = 8'(r);
    x.lk = lk; x.md = md; x.de = de; x.rv = rv;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Silence of TIMEOUT cycles since the last clear restarts (or unlocks).
  task automatic timeouts_until(input int t, input bit incl);
    while ((m_ref + TIMEOUT < t) || (incl && m_ref + TIMEOUT == t)) begin
      m_ref += TIMEOUT;
      if (m_locked) begin
        m_locked = 0; m_rate = 0;
        push_ev(m_ref, 2, 0, 0, 0, 1, 0);
      end
      m_armed = 0; m_cnt = 0; m_min = 8191;
    end
  endtask

  // Next code edge g cycles after the previous edge (or ACQ entry).
  task automatic gap(input int g);
    int t, v;
    t = m_prev + g;
    timeouts_until(t, 0);
    v = t - m_last;
    if (v > 8191) v = 8191;
    m_ref = t;
    if (!m_armed) begin
      m_armed = 1;
    end else if (!m_locked) begin
      if (v <= MAX_INT) begin
        m_cnt++;
        if (v < m_min) m_min = v;
        if (m_cnt == WIN_EDGES) begin
          if (cls(m_min) != 0) begin
            m_locked = 1; m_rate = cls(m_min); m_err = 0;
            push_ev(t, 3, m_rate, 1, 1, 1, 1);
          end
          m_cnt = 0; m_min = 8191;
        end
      end
    end else if (v <= MAX_INT && v < low_of(m_rate)) begin
      m_err++;
      if (m_err == ERR_MAX) begin
        m_locked = 0; m_rate = 0; m_armed = 0; m_cnt = 0; m_min = 8191;
        push_ev(t, 2, 0, 0, 0, 1, 0);
      end
    end
    m_last = t; m_prev = t;
    while (cyc < t - 1) step();
    code = ~code;      // seen by the DUT at cycle t
    step();
  endtask

  task automatic silence(input int n);
    int t_end;
    t_end = m_prev + n;
    timeouts_until(t_end, 1);
    while (cyc < t_end) step();
  endtask

  task automatic start_session();
    int p;
    p = cyc;
    en = 1'b1;
    push_ev(p + 1, 1, 0, 0, 0, 1, 0);
    push_ev(p + 1 + SETTLE_CYC, 2, 0, 0, 0, 1, 0);
    m_prev = p + 1 + SETTLE_CYC; m_ref = m_prev; m_last = m_prev;
    m_armed = 0; m_locked = 0; m_rate = 0; m_cnt = 0; m_min = 8191; m_err = 0;
  endtask

  task automatic stop_session();
    timeouts_until(cyc + 1, 0);
    en = 1'b0;
    push_ev(cyc + 1, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic rst_pulse();
    timeouts_until(cyc + 1, 0);
    rst = 1'b1;
    push_ev(cyc + 1, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0; en = 1'b0;
    step();
  endtask

  task automatic request(input int k);
    req_kind = k;
    req_cnt++;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    mon_on = 1;
    en = 1'b1;                 // held in reset: enable must not win
    repeat (2) step();
    request(1);
    rst = 1'b0; en = 1'b0;
    repeat (2) step();
    request(1);

    // Rate 10 lock on bin edges, then error/timeout-boundary behaviour.
    start_session();
    gap($urandom_range(60, 20));
    gap(3100);
    gap(3300);
    gap($urandom_range(3300, 3100));
    gap(1500);                 // short: error 1
    gap(3100);                 // bin floor: not an error
    gap(TIMEOUT);              // edge lands as silence would expire
    gap(1500);
    gap(1500);
    gap(1500);                 // fourth short interval: back to ACQ
    gap(100);
    gap(3200);
    stop_session();            // en dropped mid-ACQ
    request(1);
    request(2);

    // Class-0 window, a discarded long run, then rate 8; reset in LOCK.
    step();
    start_session();
    gap($urandom_range(60, 20));
    repeat (WIN_EDGES) gap($urandom_range(2100, 1900));
    gap(5800);                 // > MAX_INT: ignored
    gap(3900);
    gap(4100);
    gap($urandom_range(4100, 3900));
    silence(5);
    rst_pulse();
    request(1);
    request(2);

    // Rate 6 with an interval exactly at MAX_INT, then silence.
    start_session();
    gap($urandom_range(60, 20));
    gap(MAX_INT);
    gap(5233);
    gap($urandom_range(5433, 5233));
    silence(TIMEOUT + 50);
    stop_session();
    request(1);
    request(2);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bpsk_demod_ctrl.md
BPSK_DEMOD_CTRL -- requirements
Module: bpsk_demod_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 64, giving the cycles to wait after enable before acquisition starts (delay line fill).
REQ-002 The block SHALL have parameter WIN_EDGES, default 16, giving the accepted intervals per acquisition window.
REQ-003 The block SHALL have parameter MAX_INT, default 5500, giving the longest accepted code interval in cycles.
REQ-004 The block SHALL have parameter TIMEOUT, default 60000, giving the silence cycles without a code edge before a window restart or loss of lock.
REQ-005 The block SHALL have parameter ERR_MAX, default 4, giving the short-interval errors in LOCK that force reacquisition.
REQ-006 The block SHALL have port clk_32m, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have port en, input, 1 bit: controller enable.
REQ-009 The block SHALL have port code, input, 1 bit: recovered code level from the demodulator.
REQ-010 The block SHALL have port demod_en, output, 1 bit: demodulator run enable.
REQ-011 The block SHALL have port mode, output, 1 bit: demod output select, 1 = decoded code and 0 = raw passthrough.
REQ-012 The block SHALL have port locked, output, 1 bit: rate lock indicator.
REQ-013 The block SHALL have port rate, output, 8 bits: code rate in kbps, one of 0, 6, 8 or 10.
REQ-014 The block SHALL have port rate_valid, output, 1 bit: one-cycle pulse when rate is newly set.
REQ-015 The block SHALL have port state, output, 2 bits: FSM state, IDLE=0, SETTLE=1, ACQ=2, LOCK=3.

Function
REQ-016 Edge detect SHALL register code into code_d; edge = code XOR code_d; the first edge after entering ACQ SHALL only arm the interval counter and produce no measurement.
REQ-017 The 13-bit interval counter SHALL clear on each edge, increment otherwise and saturate at 8191; on an edge the measured interval SHALL be counter+1 (saturating at 8191).
REQ-018 Measured intervals greater than MAX_INT SHALL be discarded and SHALL NOT count toward the window.
REQ-019 Classification of an interval v SHALL give: 3100<=v<=3300 -> 10; 3900<=v<=4100 -> 8; 5233<=v<=5433 -> 6; any other value -> 0.
REQ-020 IDLE SHALL drive demod_en=0, mode=0 and locked=0, and SHALL go to SETTLE when en=1.
REQ-021 SETTLE SHALL drive demod_en=1, count SETTLE_CYC cycles and then go to ACQ.
REQ-022 ACQ SHALL track the minimum accepted interval (init 8191) and the count of accepted intervals.
REQ-023 When the accepted count reaches WIN_EDGES and class(min) is nonzero, ACQ SHALL go to LOCK next cycle with rate=class, rate_valid=1 for one cycle, locked=1 and mode=1.
REQ-024 When the accepted count reaches WIN_EDGES and class(min) is 0, ACQ SHALL restart the window (min=8191, count=0) and remain in ACQ.
REQ-025 A 16-bit silence counter SHALL clear on each edge and increment otherwise; reaching TIMEOUT in ACQ SHALL restart the window and disarm the interval counter.
REQ-026 On entry to LOCK, err_cnt SHALL clear; each accepted interval below the locked bin lower bound (3100/3900/5233) SHALL increment err_cnt.
REQ-027 In LOCK, err_cnt reaching ERR_MAX or the silence counter reaching TIMEOUT SHALL go to ACQ with locked=0, mode=0, rate=0 and a fresh window.
REQ-028 An edge in the same cycle the silence counter would reach TIMEOUT SHALL win: the counter clears and the state holds.
REQ-029 en=0 in any state SHALL force IDLE next cycle and clear all counters, rate, locked, mode and demod_en; en has priority over every other transition.
REQ-030 rate SHALL hold its value throughout LOCK and change only on LOCK entry or exit.

Reset
REQ-031 With rst=1 at a clock edge, the block SHALL set state=IDLE, demod_en=0, mode=0, locked=0, rate=0, rate_valid=0, code_d=0, all counters 0, min interval 8191, and reset SHALL override en.
REQ-032 Reset mid-LOCK SHALL take effect on the next edge with no rate_valid pulse.

Verification
REQ-033 en=1, code toggling every 3200 cycles -> SETTLE lasts 64 cycles; after the arm edge plus 16 intervals: rate=10, one rate_valid pulse, locked=1, mode=1.
REQ-034 Code with mixed runs of 4000 and 8000 cycles -> 8000 intervals discarded, min=4000, rate=8 lock after 16 accepted intervals.
REQ-035 Code toggling every 2000 cycles -> class 0, window restarts repeatedly, locked stays 0, no rate_valid.
REQ-036 Locked at 5333 (rate=6), code then held constant for 60000 cycles -> ACQ, locked=0, rate=0.
REQ-037 Locked at rate=10, then 4 intervals of 1500 cycles -> ACQ on the fourth; an edge exactly at silence count TIMEOUT-1 keeps LOCK.
REQ-038 en dropped mid-ACQ, and separately rst pulsed in LOCK -> IDLE next cycle with all outputs 0.
